otter_cu_fsm: RTL and testbench

//  Multicycle control-unit sequencer for the OTTER RV32I core. Steps each instruction through

---
 rtl/otter_cu_pkg.sv | 27 ++
 rtl/otter_wait_timer.sv | 38 +++
 rtl/otter_cu_fsm.sv | 165 ++++++++++++++++
 tb/tb_otter_cu_fsm.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_cu_pkg.sv
// Shared types and ISA constants for the OTTER multicycle control unit.
`timescale 1ns/1ps
package otter_cu_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        INTR  = 3'd4,
        FAULT = 3'd5
    } cu_state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYS    = 7'b1110011;

    localparam logic [2:0] FUNCT_MRET = 3'b000;

endpackage

// File: rtl/otter_wait_timer.sv
// Memory-acknowledge watchdog: counts stalled cycles and flags the cycle in which the limit is hit.
`timescale 1ns/1ps
module otter_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    generate
        if (MEM_TIMEOUT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            localparam int unsigned W = $clog2(MEM_TIMEOUT + 1);
            localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

            logic [W-1:0] wait_cnt;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    wait_cnt <= '0;
                end else if (clear) begin
                    wait_cnt <= '0;
                end else if (count_en) begin
                    wait_cnt <= wait_cnt + W'(1);
                end
            end

            // Expires on the stalled cycle that would make the count reach the limit,
            // so an ACK in that cycle (count_en low) always wins.
            assign expired = count_en && (wait_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/otter_cu_fsm.sv
// OTTER RV32I multicycle control sequencer: fetch / execute / writeback with
// interrupt entry at instruction boundaries and a sticky memory-timeout fault.
`timescale 1ns/1ps
module otter_cu_fsm
    import otter_cu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [6:0]       IR_OPCODE,
    input  logic [2:0]       IR_FUNCT,
    input  logic             INTR,
    input  logic             CSR_MIE,
    input  logic             MEM_ACK,
    output logic             RST_OUT,
    output logic             PC_WE,
    output logic             RF_WE,
    output logic             MEM_RDEN1,
    output logic             MEM_RDEN2,
    output logic             MEM_WE2,
    output logic             CSR_WE,
    output logic             INT_TAKEN,
    output logic             MRET_EXEC,
    output logic             ILLEGAL_OP,
    output logic             MEM_FAULT,
    output logic [CNT_W-1:0] RET_CNT
);

    // state | meaning
    // INIT  | one-cycle RST_OUT to PC and register file after reset
    // FETCH | instruction read, waits for MEM_ACK
    // EXEC  | decode and issue; non-load instructions complete here
    // WB    | load data wait; completes on MEM_ACK
    // INTR  | interrupt entry, PC takes mtvec
    // FAULT | memory never acknowledged; left only through RST_N

    // The INTR port shadows the imported state name, so the state gets a local alias.
    localparam cu_state_t S_INTR = otter_cu_pkg::INTR;

    cu_state_t state;
    cu_state_t state_next;
    logic      intr_req;
    logic      retire;
    logic      wait_clear;
    logic      wait_count_en;
    logic      wait_expired;

    assign intr_req      = INTR & CSR_MIE;
    assign wait_count_en = ((state == FETCH) || (state == WB)) && !MEM_ACK;
    assign wait_clear    = (state_next != state);

    otter_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clear    (wait_clear),
        .count_en (wait_count_en),
        .expired  (wait_expired)
    );

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        RST_OUT    = 1'b0;
        PC_WE      = 1'b0;
        RF_WE      = 1'b0;
        MEM_RDEN1  = 1'b0;
        MEM_RDEN2  = 1'b0;
        MEM_WE2    = 1'b0;
        CSR_WE     = 1'b0;
        INT_TAKEN  = 1'b0;
        MRET_EXEC  = 1'b0;
        ILLEGAL_OP = 1'b0;

        case (state)
            INIT: begin
                RST_OUT    = 1'b1;
                state_next = FETCH;
            end

            FETCH: begin
                MEM_RDEN1 = 1'b1;
                if (MEM_ACK) begin
                    state_next = EXEC;
                end else if (wait_expired) begin
                    state_next = FAULT;
                end
            end

            EXEC: begin
                PC_WE  = 1'b1;
                retire = 1'b1;
                case (IR_OPCODE)
                    OPC_LOAD: begin
                        MEM_RDEN2 = 1'b1;
                        PC_WE     = 1'b0;
                        retire    = 1'b0;
                    end
                    OPC_STORE:  MEM_WE2 = 1'b1;
                    OPC_BRANCH: begin
                    end
                    OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP, OPC_JAL, OPC_JALR: begin
                        RF_WE = 1'b1;
                    end
                    OPC_SYS: begin
                        if (IR_FUNCT == FUNCT_MRET) begin
                            MRET_EXEC = 1'b1;
                        end else begin
                            CSR_WE = 1'b1;
                            RF_WE  = 1'b1;
                        end
                    end
                    default: ILLEGAL_OP = 1'b1;
                endcase
                if (retire) begin
                    state_next = intr_req ? S_INTR : FETCH;
                end else begin
                    state_next = WB;
                end
            end

            WB: begin
                if (MEM_ACK) begin
                    RF_WE      = 1'b1;
                    PC_WE      = 1'b1;
                    retire     = 1'b1;
                    state_next = intr_req ? S_INTR : FETCH;
                end else if (wait_expired) begin
                    state_next = FAULT;
                end
            end

            S_INTR: begin
                INT_TAKEN  = 1'b1;
                PC_WE      = 1'b1;
                state_next = FETCH;
            end

            FAULT: begin
            end

            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= INIT;
            RET_CNT   <= '0;
            MEM_FAULT <= 1'b0;
        end else begin
            state <= state_next;
            if (retire) begin
                RET_CNT <= RET_CNT + CNT_W'(1);
            end
            if (state_next == FAULT) begin
                MEM_FAULT <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Self-checking bench for otter_cu_fsm: per-cycle stimulus rows, expected strobes and
// retired count queued on drive and compared at the following falling edge.
`timescale 1ns/1ps
module tb_otter_cu_fsm;

    localparam int CNT_W = 4;

    // Expected strobe vector bit positions, matching outs() below.
    localparam logic [10:0] B_NONE = 11'h000;
    localparam logic [10:0] B_RST  = 11'h400;
    localparam logic [10:0] B_PC   = 11'h200;
    localparam logic [10:0] B_RF   = 11'h100;
    localparam logic [10:0] B_RD1  = 11'h080;
    localparam logic [10:0] B_RD2  = 11'h040;
    localparam logic [10:0] B_WE2  = 11'h020;
    localparam logic [10:0] B_CSR  = 11'h010;
    localparam logic [10:0] B_INT  = 11'h008;
    localparam logic [10:0] B_MRET = 11'h004;
    localparam logic [10:0] B_ILL  = 11'h002;
    localparam logic [10:0] B_FLT  = 11'h001;

    // Control nibble {RST_N, MEM_ACK, INTR, CSR_MIE}.
    localparam logic [3:0] C_RST     = 4'b0000;
    localparam logic [3:0] C_RST_ACK = 4'b0100;
    localparam logic [3:0] C_WAIT    = 4'b1000;
    localparam logic [3:0] C_ACK     = 4'b1100;
    localparam logic [3:0] C_INT     = 4'b1011;
    localparam logic [3:0] C_ACK_INT = 4'b1111;
    localparam logic [3:0] C_INT_OFF = 4'b1010;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    typedef struct {
        logic [3:0]  ctl;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [10:0] exp;
        bit          done;
    } row_t;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b1;
    logic [6:0]       IR_OPCODE = '0;
    logic [2:0]       IR_FUNCT = '0;
    logic             INTR = 1'b0;
    logic             CSR_MIE = 1'b0;
    logic             MEM_ACK = 1'b0;
    logic             RST_OUT, PC_WE, RF_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2;
    logic             CSR_WE, INT_TAKEN, MRET_EXEC, ILLEGAL_OP, MEM_FAULT;
    logic [CNT_W-1:0] RET_CNT;

    logic [10:0]      sb_out[$];
    logic [CNT_W-1:0] sb_cnt[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    int               n_checks = 0;
    int               n_fail = 0;

    otter_cu_fsm #(
        .MEM_TIMEOUT (4),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IR_OPCODE  (IR_OPCODE),
        .IR_FUNCT   (IR_FUNCT),
        .INTR       (INTR),
        .CSR_MIE    (CSR_MIE),
        .MEM_ACK    (MEM_ACK),
        .RST_OUT    (RST_OUT),
        .PC_WE      (PC_WE),
        .RF_WE      (RF_WE),
        .MEM_RDEN1  (MEM_RDEN1),
        .MEM_RDEN2  (MEM_RDEN2),
        .MEM_WE2    (MEM_WE2),
        .CSR_WE     (CSR_WE),
        .INT_TAKEN  (INT_TAKEN),
        .MRET_EXEC  (MRET_EXEC),
        .ILLEGAL_OP (ILLEGAL_OP),
        .MEM_FAULT  (MEM_FAULT),
        .RET_CNT    (RET_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [10:0] outs();
        return {RST_OUT, PC_WE, RF_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
                CSR_WE, INT_TAKEN, MRET_EXEC, ILLEGAL_OP, MEM_FAULT};
    endfunction

    function automatic row_t mk(logic [3:0] ctl, logic [6:0] opc, logic [2:0] f3,
                                logic [10:0] exp, bit done);
        row_t r;
        r.ctl = ctl; r.opc = opc; r.f3 = f3; r.exp = exp; r.done = done;
        return r;
    endfunction

    // Drives one cycle of stimulus just after the rising edge and queues what the
    // falling-edge sample must show; reset zeroes the expected count immediately.
    task automatic drive_row(input row_t r);
        @(posedge CLK);
        #1;
        {RST_N, MEM_ACK, INTR, CSR_MIE} = r.ctl;
        IR_OPCODE = r.opc;
        IR_FUNCT  = r.f3;
        if (!r.ctl[3]) exp_cnt = '0;
        sb_out.push_back(r.exp);
        sb_cnt.push_back(exp_cnt);
        if (r.done) exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        logic [10:0] want;
        logic [CNT_W-1:0] want_cnt;
        rows.push_back(mk(C_RST, OP_ADDI, 3'b000, B_RST, 1'b0));
        rows.push_back(mk(C_RST_ACK, OP_ADDI, 3'b000, B_RST, 1'b0));
        rows.push_back(mk(C_ACK, OP_ADDI, 3'b000, B_RST, 1'b0));
        rows.push_back(mk(C_ACK, OP_ADDI, 3'b000, B_RD1, 1'b0));
        rows.push_back(mk(C_WAIT, OP_ADDI, 3'b000, B_PC | B_RF, 1'b1));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge CLK);
            want = sb_out.pop_front();
            want_cnt = sb_cnt.pop_front();
            n_checks += 2;
            if (outs() !== want) begin
                n_fail++;
                $display("FAIL reset row %0d strobes: got %b want %b", i, outs(), want);
            end
            if (RET_CNT !== want_cnt) begin
                n_fail++;
                $display("FAIL reset row %0d ret_cnt: got %0d want %0d", i, RET_CNT, want_cnt);
            end
        end
    endtask

    task automatic test_addi();
        row_t rows[$];
        logic [10:0] want;
        logic [CNT_W-1:0] want_cnt;
        for (int k = 0; k < 3; k++) rows.push_back(mk(C_WAIT, OP_ADDI, 3'b000, B_RD1, 1'b0));
        rows.push_back(mk(C_ACK, OP_ADDI, 3'b000, B_RD1, 1'b0));
        rows.push_back(mk(C_WAIT, OP_ADDI, 3'b000, B_PC | B_RF, 1'b1));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge CLK);
            want = sb_out.pop_front();
            want_cnt = sb_cnt.pop_front();
            n_checks += 2;
            if (outs() !== want) begin
                n_fail++;
                $display("FAIL addi row %0d strobes: got %b want %b", i, outs(), want);
            end
            if (RET_CNT !== want_cnt) begin
                n_fail++;
                $display("FAIL addi row %0d ret_cnt: got %0d want %0d", i, RET_CNT, want_cnt);
            end
        end
    endtask

    task automatic test_load();
        row_t rows[$];
        logic [10:0] want;
        logic [CNT_W-1:0] want_cnt;
        rows.push_back(mk(C_ACK, OP_LOAD, 3'b010, B_RD1, 1'b0));
        rows.push_back(mk(C_WAIT, OP_LOAD, 3'b010, B_RD2, 1'b0));
        rows.push_back(mk(C_WAIT, OP_LOAD, 3'b010, B_NONE, 1'b0));
        rows.push_back(mk(C_WAIT, OP_LOAD, 3'b010, B_NONE, 1'b0));
        rows.push_back(mk(C_ACK, OP_LOAD, 3'b010, B_PC | B_RF, 1'b1));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge CLK);
            want = sb_out.pop_front();
            want_cnt = sb_cnt.pop_front();
            n_checks += 2;
            if (outs() !== want) begin
                n_fail++;
                $display("FAIL load row %0d strobes: got %b want %b", i, outs(), want);
            end
            if (RET_CNT !== want_cnt) begin
                n_fail++;
                $display("FAIL load row %0d ret_cnt: got %0d want %0d", i, RET_CNT, want_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        logic [10:0] want;
        logic [CNT_W-1:0] want_cnt;
        rows.push_back(mk(C_ACK, OP_STORE, 3'b010, B_RD1, 1'b0));
        rows.push_back(mk(C_INT, OP_STORE, 3'b010, B_WE2 | B_PC, 1'b1));
        rows.push_back(mk(C_INT, OP_STORE, 3'b010, B_INT | B_PC, 1'b0));
        rows.push_back(mk(C_ACK_INT, OP_STORE, 3'b010, B_RD1, 1'b0));
        rows.push_back(mk(C_INT_OFF, OP_STORE, 3'b010, B_WE2 | B_PC, 1'b1));
        rows.push_back(mk(C_ACK, OP_LOAD, 3'b010, B_RD1, 1'b0));
        rows.push_back(mk(C_INT, OP_LOAD, 3'b010, B_RD2, 1'b0));
        rows.push_back(mk(C_ACK_INT, OP_LOAD, 3'b010, B_PC | B_RF, 1'b1));
        rows.push_back(mk(C_WAIT, OP_LOAD, 3'b010, B_INT | B_PC, 1'b0));
        rows.push_back(mk(C_ACK, OP_SYS, 3'b000, B_RD1, 1'b0));
        rows.push_back(mk(C_INT, OP_SYS, 3'b000, B_MRET | B_PC, 1'b1));
        rows.push_back(mk(C_WAIT, OP_SYS, 3'b000, B_INT | B_PC, 1'b0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge CLK);
            want = sb_out.pop_front();
            want_cnt = sb_cnt.pop_front();
            n_checks += 2;
            if (outs() !== want) begin
                n_fail++;
                $display("FAIL b2b row %0d strobes: got %b want %b", i, outs(), want);
            end
            if (RET_CNT !== want_cnt) begin
                n_fail++;
                $display("FAIL b2b row %0d ret_cnt: got %0d want %0d", i, RET_CNT, want_cnt);
            end
        end
    endtask

    task automatic test_decode();
        row_t rows[$];
        logic [10:0] want;
        logic [CNT_W-1:0] want_cnt;
        logic [6:0] rf_ops [5] = '{7'b0110111, 7'b0010111, 7'b0110011, 7'b1101111, 7'b1100111};
        rows.push_back(mk(C_ACK, OP_BAD, 3'b000, B_RD1, 1'b0));
        rows.push_back(mk(C_WAIT, OP_BAD, 3'b000, B_ILL | B_PC, 1'b1));
        rows.push_back(mk(C_ACK, OP_SYS, 3'b001, B_RD1, 1'b0));
        rows.push_back(mk(C_WAIT, OP_SYS, 3'b001, B_CSR | B_RF | B_PC, 1'b1));
        rows.push_back(mk(C_ACK, OP_SYS, 3'b000, B_RD1, 1'b0));
        rows.push_back(mk(C_WAIT, OP_SYS, 3'b000, B_MRET | B_PC, 1'b1));
        rows.push_back(mk(C_ACK, OP_BRANCH, 3'b001, B_RD1, 1'b0));
        rows.push_back(mk(C_WAIT, OP_BRANCH, 3'b001, B_PC, 1'b1));
        foreach (rf_ops[k]) begin
            rows.push_back(mk(C_ACK, rf_ops[k], 3'b000, B_RD1, 1'b0));
            rows.push_back(mk(C_WAIT, rf_ops[k], 3'b000, B_PC | B_RF, 1'b1));
        end
        // Counter is 4 bits wide here, so this ADDI observes the wrap to zero.
        rows.push_back(mk(C_ACK, OP_ADDI, 3'b000, B_RD1, 1'b0));
        rows.push_back(mk(C_WAIT, OP_ADDI, 3'b000, B_PC | B_RF, 1'b1));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge CLK);
            want = sb_out.pop_front();
            want_cnt = sb_cnt.pop_front();
            n_checks += 2;
            if (outs() !== want) begin
                n_fail++;
                $display("FAIL decode row %0d strobes: got %b want %b", i, outs(), want);
            end
            if (RET_CNT !== want_cnt) begin
                n_fail++;
                $display("FAIL decode row %0d ret_cnt: got %0d want %0d", i, RET_CNT, want_cnt);
            end
        end
    endtask

    task automatic test_timeout();
        row_t rows[$];
        logic [10:0] want;
        logic [CNT_W-1:0] want_cnt;
        for (int k = 0; k < 3; k++) rows.push_back(mk(C_WAIT, OP_ADDI, 3'b000, B_RD1, 1'b0));
        rows.push_back(mk(C_ACK, OP_ADDI, 3'b000, B_RD1, 1'b0));
        rows.push_back(mk(C_WAIT, OP_ADDI, 3'b000, B_PC | B_RF, 1'b1));
        for (int k = 0; k < 4; k++) rows.push_back(mk(C_WAIT, OP_ADDI, 3'b000, B_RD1, 1'b0));
        rows.push_back(mk(C_ACK, OP_ADDI, 3'b000, B_FLT, 1'b0));
        rows.push_back(mk(C_ACK, OP_ADDI, 3'b000, B_FLT, 1'b0));
        rows.push_back(mk(C_RST, OP_LOAD, 3'b010, B_RST, 1'b0));
        rows.push_back(mk(C_ACK, OP_LOAD, 3'b010, B_RST, 1'b0));
        rows.push_back(mk(C_ACK, OP_LOAD, 3'b010, B_RD1, 1'b0));
        rows.push_back(mk(C_WAIT, OP_LOAD, 3'b010, B_RD2, 1'b0));
        for (int k = 0; k < 4; k++) rows.push_back(mk(C_WAIT, OP_LOAD, 3'b010, B_NONE, 1'b0));
        rows.push_back(mk(C_WAIT, OP_LOAD, 3'b010, B_FLT, 1'b0));
        rows.push_back(mk(C_RST, OP_ADDI, 3'b000, B_RST, 1'b0));
        rows.push_back(mk(C_WAIT, OP_ADDI, 3'b000, B_RST, 1'b0));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge CLK);
            want = sb_out.pop_front();
            want_cnt = sb_cnt.pop_front();
            n_checks += 2;
            if (outs() !== want) begin
                n_fail++;
                $display("FAIL timeout row %0d strobes: got %b want %b", i, outs(), want);
            end
            if (RET_CNT !== want_cnt) begin
                n_fail++;
                $display("FAIL timeout row %0d ret_cnt: got %0d want %0d", i, RET_CNT, want_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_wb();
        row_t rows[$];
        logic [10:0] want;
        logic [CNT_W-1:0] want_cnt;
        rows.push_back(mk(C_ACK, OP_ADDI, 3'b000, B_RD1, 1'b0));
        rows.push_back(mk(C_WAIT, OP_ADDI, 3'b000, B_PC | B_RF, 1'b1));
        rows.push_back(mk(C_ACK, OP_LOAD, 3'b010, B_RD1, 1'b0));
        rows.push_back(mk(C_WAIT, OP_LOAD, 3'b010, B_RD2, 1'b0));
        rows.push_back(mk(C_WAIT, OP_LOAD, 3'b010, B_NONE, 1'b0));
        rows.push_back(mk(C_RST_ACK, OP_LOAD, 3'b010, B_RST, 1'b0));
        rows.push_back(mk(C_ACK, OP_ADDI, 3'b000, B_RST, 1'b0));
        rows.push_back(mk(C_ACK, OP_ADDI, 3'b000, B_RD1, 1'b0));
        rows.push_back(mk(C_WAIT, OP_ADDI, 3'b000, B_PC | B_RF, 1'b1));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge CLK);
            want = sb_out.pop_front();
            want_cnt = sb_cnt.pop_front();
            n_checks += 2;
            if (outs() !== want) begin
                n_fail++;
                $display("FAIL rst_mid_wb row %0d strobes: got %b want %b", i, outs(), want);
            end
            if (RET_CNT !== want_cnt) begin
                n_fail++;
                $display("FAIL rst_mid_wb row %0d ret_cnt: got %0d want %0d", i, RET_CNT, want_cnt);
            end
        end
    endtask

    initial begin
        RST_N = 1'b0;
        test_reset();
        test_addi();
        test_load();
        test_back_to_back();
        test_decode();
        test_timeout();
        test_reset_mid_wb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
